// File: rtl/aes_pkg.sv
// Shared constants, FSM state encoding and the reference xtime function
// for the AES round datapath.
package aes_pkg;

  localparam logic [7:0] XTIME_POLY = 8'h1B;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_X2   = 3'd1,
    ST_X4   = 3'd2,
    ST_X8   = 3'd3,
    ST_MIX  = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Combinational GF(2^8) multiply-by-2 over the AES polynomial.
module gf_xtime
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = {a[6:0], 1'b0} ^ ({8{a[7]}} & XTIME_POLY);

endmodule

// File: rtl/mixcol_seq.sv
// Iterative MixColumns / InvMixColumns engine: one column at a time through
// four shared xtime units, valid/ready on both sides.
module mixcol_seq
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam logic [1:0] COL_LAST = 2'(NB - 1);

  state_t       state;
  state_t       state_nx;
  logic [1:0]   col;
  logic         mode;
  logic [127:0] work;
  logic [127:0] work_mixed;
  logic [31:0]  cur_col;
  logic [7:0]   a    [4];
  logic [7:0]   x2   [4];
  logic [7:0]   x4   [4];
  logic [7:0]   x8   [4];
  logic [7:0]   xin  [4];
  logic [7:0]   xout [4];
  logic [7:0]   b    [4];

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Select the active column out of the working register.
  always_comb begin
    case (col)
      2'd0:    cur_col = work[127:96];
      2'd1:    cur_col = work[95:64];
      2'd2:    cur_col = work[63:32];
      2'd3:    cur_col = work[31:0];
      default: cur_col = work[127:96];
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign a[i] = cur_col[31-8*i -: 8];
    gf_xtime u_xtime (.a(xin[i]), .y(xout[i]));
  end

  // The xtime units are chained through registers: a -> x2 -> x4 -> x8.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      case (state)
        ST_X4:   xin[i] = x2[i];
        ST_X8:   xin[i] = x4[i];
        default: xin[i] = a[i];
      endcase
    end
  end

  // Column mix: 2,3,1,1 circulant for encrypt, 14,11,13,9 for decrypt.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (mode == MODE_DEC) begin
        b[i] = (x8[i] ^ x4[i] ^ x2[i])
             ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
             ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
             ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      end else begin
        b[i] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
  end

  // Working state with the mixed column written back in place.
  always_comb begin
    work_mixed = work;
    case (col)
      2'd0:    work_mixed[127:96] = {b[0], b[1], b[2], b[3]};
      2'd1:    work_mixed[95:64]  = {b[0], b[1], b[2], b[3]};
      2'd2:    work_mixed[63:32]  = {b[0], b[1], b[2], b[3]};
      2'd3:    work_mixed[31:0]   = {b[0], b[1], b[2], b[3]};
      default: work_mixed = work;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = ST_X2; else state_nx = ST_IDLE;
      ST_X2:   if (mode == MODE_DEC) state_nx = ST_X4; else state_nx = ST_MIX;
      ST_X4:   state_nx = ST_X8;
      ST_X8:   state_nx = ST_MIX;
      ST_MIX:  if (col == COL_LAST) state_nx = ST_OUT; else state_nx = ST_X2;
      ST_OUT:  if (out_ready) state_nx = ST_IDLE; else state_nx = ST_OUT;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      col       <= 2'd0;
      mode      <= MODE_ENC;
      work      <= 128'd0;
      out_state <= 128'd0;
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x2[i] <= 8'h00;
        x4[i] <= 8'h00;
        x8[i] <= 8'h00;
      end
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work <= in_state;
            mode <= in_mode;
            col  <= 2'd0;
          end
        end
        ST_X2: for (int i = 0; i < 4; i++) x2[i] <= xout[i];
        ST_X4: for (int i = 0; i < 4; i++) x4[i] <= xout[i];
        ST_X8: for (int i = 0; i < 4; i++) x8[i] <= xout[i];
        ST_MIX: begin
          work <= work_mixed;
          if (col == COL_LAST) begin
            out_state <= work_mixed;
            out_valid <= 1'b1;
          end else begin
            col <= col + 2'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            col       <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcol_seq.sv
// Directed bench for mixcol_seq: table of known-answer states plus
// backpressure, mid-operation reset and exhaustive xtime sequences.
module tb_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [7:0]   xa;
  logic [7:0]   xy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mixcol_seq #(.NB(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .busy     (busy)
  );

  gf_xtime u_xt (.a(xa), .y(xy));

  typedef struct {
    logic         mode;
    logic [127:0] din;
    logic [127:0] dout;
    int           lat;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Polynomial-reduction reference: shift into 9 bits, reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_x2(input logic [7:0] v);
    logic [8:0] t;
    t = {v, 1'b0};
    if (t >= 9'h100) t = t ^ 9'h11B;
    return t[7:0];
  endfunction

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic run_op(input logic m, input logic [127:0] d, input logic [127:0] e,
                        input int lat, input string name);
    int cnt;
    @(negedge clk);
    check({name, " in_ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_state = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = 128'd0;
    wait_out(cnt);
    check({name, " latency"}, 128'(cnt), 128'(lat));
    check({name, " out_state"}, out_state, e);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " out_valid cleared"}, 128'(out_valid), 128'd0);
    check({name, " in_ready after handshake"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bit stuck;

    tbl[0] = '{1'b0, 128'hdb135345_f20a225c_01010101_2d26314c, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 8};
    tbl[1] = '{1'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 8};
    tbl[2] = '{1'b1, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 128'hdb135345_f20a225c_01010101_2d26314c, 16};
    tbl[3] = '{1'b1, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 16};
    tbl[4] = '{1'b0, 128'd0, 128'd0, 8};
    tbl[5] = '{1'b1, {16{8'hc6}}, {16{8'hc6}}, 16};
    tbl[6] = '{1'b0, {16{8'h01}}, {16{8'h01}}, 8};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_state = 128'd0; out_ready = 1'b0; xa = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset out_state", out_state, 128'd0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++)
      run_op(tbl[k].mode, tbl[k].din, tbl[k].dout, tbl[k].lat, $sformatf("vec%0d", k));

    // Backpressure: result held for 10 cycles, a stray in_valid is ignored.
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_state = tbl[1].din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(cnt);
    check("bp latency", 128'(cnt), 128'd8);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp out_valid c%0d", k), 128'(out_valid), 128'd1);
      check($sformatf("bp out_state c%0d", k), out_state, tbl[1].dout);
      check($sformatf("bp in_ready c%0d", k), 128'(in_ready), 128'd0);
      if (k == 3) begin
        in_valid = 1'b1; in_mode = 1'b1; in_state = tbl[0].din;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp out_valid cleared", 128'(out_valid), 128'd0);
    check("bp in_ready", 128'(in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp stray not latched", 128'(busy), 128'd0);

    // Reset in column 2 of a decrypt.
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b1; in_state = tbl[2].din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort busy before rst", 128'(busy), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort out_valid", 128'(out_valid), 128'd0);
    check("abort busy", 128'(busy), 128'd0);
    check("abort in_ready", 128'(in_ready), 128'd1);
    check("abort out_state", out_state, 128'd0);
    stuck = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) stuck = 1'b1;
    end
    check("abort no partial result", 128'(stuck), 128'd0);
    run_op(1'b0, {16{8'hc6}}, {16{8'hc6}}, 8, "post-abort enc");

    // Exhaustive xtime against the reduction reference and the package function.
    for (int i = 0; i < 256; i++) begin
      xa = 8'(i);
      #1;
      check($sformatf("gf_xtime %02h", i), 128'(xy), 128'(ref_x2(xa)));
      check($sformatf("mul2 %02h", i), 128'(aes_pkg::mul2(xa)), 128'(ref_x2(xa)));
    end
    xa = 8'h80; #1; check("xtime 80", 128'(xy), 128'h1B);
    xa = 8'hFF; #1; check("xtime FF", 128'(xy), 128'hE5);
    xa = 8'h57; #1; check("xtime 57", 128'(xy), 128'hAE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
